// File: rtl/div_arb_if.sv
// -----------------------------------------------------------------------------
// div_arb_if
// Bundles every non-clock/reset signal of div_arb.
//
// Requester side:
//   req0/req1   level requests, held with operands stable until the matching ack
//   a0/b0/a1/b1 dividend/divisor per requester
//   ack0/ack1   one-cycle completion pulse to the owning requester
//   q/r/dz      quotient, remainder, divide-by-zero flag (held until next completion)
//   busy        arbiter is not idle
// Divider side:
//   div_ld      divider load strobe
//   div_a/div_b divider operands
//   div_ry      divider quotient
//   div_ra      divider remainder register (low W bits are the remainder)
//
// Modports:
//   slave  - the arbiter itself
//   master - everything around it (requesters and the shared divider)
// -----------------------------------------------------------------------------
interface div_arb_if #(
    parameter int W = 4
) ();
    logic             req0;
    logic             req1;
    logic [W-1:0]     a0;
    logic [W-1:0]     b0;
    logic [W-1:0]     a1;
    logic [W-1:0]     b1;
    logic             ack0;
    logic             ack1;
    logic [W-1:0]     q;
    logic [W-1:0]     r;
    logic             dz;
    logic             busy;
    logic             div_ld;
    logic [W-1:0]     div_a;
    logic [W-1:0]     div_b;
    logic [W-1:0]     div_ry;
    logic [2*W-1:0]   div_ra;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, div_ry, div_ra,
        output ack0, ack1, q, r, dz, busy, div_ld, div_a, div_b
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, div_ry, div_ra,
        input  ack0, ack1, q, r, dz, busy, div_ld, div_a, div_b
    );
endinterface

// File: rtl/div_arb.sv
// -----------------------------------------------------------------------------
// div_arb
// Round-robin arbiter and sequencer for a shared multi-cycle restoring divider.
// Grants one of two requesters, latches its operands, loads the divider, waits
// STEPS step cycles, captures quotient/remainder and returns them with a
// one-cycle acknowledge. A zero divisor bypasses the divider entirely and
// reports q = all ones, r = dividend, dz = 1.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous, active-low reset
//   bus  - div_arb_if.slave: requester handshake, results and divider strobes
//
// Parameters:
//   W     - operand width
//   STEPS - divider step cycles after load (equals W for the restoring divider)
// -----------------------------------------------------------------------------
module div_arb #(
    parameter int W     = 4,
    parameter int STEPS = 4
) (
    input  logic     clk,
    input  logic     rst,
    div_arb_if.slave bus
);

    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_CAPT = 3'd3;
    localparam logic [2:0] S_ACK  = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic [CW-1:0] cnt;
    logic          owner;
    logic          owner_nx;
    logic          last_g;
    logic          grant;
    logic          any_req;
    logic [W-1:0]  sel_a;
    logic [W-1:0]  sel_b;

    logic [W-1:0]  div_a_r;
    logic [W-1:0]  div_b_r;
    logic [W-1:0]  q_r;
    logic [W-1:0]  r_r;
    logic          dz_r;
    logic          ack0_r;
    logic          ack1_r;
    logic          busy_r;
    logic          ld_r;

    // Upper half of the divider's remainder register is working state only.
    logic [W-1:0]  div_ra_hi_unused;
    assign div_ra_hi_unused = bus.div_ra[2*W-1:W];

    assign bus.div_a  = div_a_r;
    assign bus.div_b  = div_b_r;
    assign bus.q      = q_r;
    assign bus.r      = r_r;
    assign bus.dz     = dz_r;
    assign bus.ack0   = ack0_r;
    assign bus.ack1   = ack1_r;
    assign bus.busy   = busy_r;
    assign bus.div_ld = ld_r;

    // On a tie the requester that was not granted last wins; otherwise the
    // single active requester is chosen.
    always_comb begin
        any_req = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            grant = ~last_g;
        end else begin
            grant = bus.req1;
        end
        sel_a = grant ? bus.a1 : bus.a0;
        sel_b = grant ? bus.b1 : bus.b0;
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    owner_nx = grant;
                    state_nx = (sel_b == '0) ? S_ACK : S_LOAD;
                end
            end
            S_LOAD:  state_nx = S_RUN;
            S_RUN:   if (cnt == CW'(STEPS - 1)) state_nx = S_CAPT;
            S_CAPT:  state_nx = S_ACK;
            S_ACK:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // All outputs are registered: strobes are derived from the next state so
    // they line up with the cycle the FSM actually occupies.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            owner   <= 1'b0;
            last_g  <= 1'b1;
            cnt     <= '0;
            div_a_r <= '0;
            div_b_r <= '0;
            q_r     <= '0;
            r_r     <= '0;
            dz_r    <= 1'b0;
            ack0_r  <= 1'b0;
            ack1_r  <= 1'b0;
            busy_r  <= 1'b0;
            ld_r    <= 1'b0;
        end else begin
            state  <= state_nx;
            owner  <= owner_nx;
            ld_r   <= (state_nx == S_LOAD);
            busy_r <= (state_nx != S_IDLE);
            ack0_r <= (state_nx == S_ACK) && !owner_nx;
            ack1_r <= (state_nx == S_ACK) &&  owner_nx;

            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        last_g  <= grant;
                        div_a_r <= sel_a;
                        div_b_r <= sel_b;
                        // Zero divisor: result is known now, divider untouched.
                        if (sel_b == '0) begin
                            q_r  <= '1;
                            r_r  <= sel_a;
                            dz_r <= 1'b1;
                        end
                    end
                end
                S_LOAD: cnt <= '0;
                S_RUN:  cnt <= cnt + CW'(1);
                S_CAPT: begin
                    q_r  <= bus.div_ry;
                    r_r  <= bus.div_ra[W-1:0];
                    dz_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arb.sv
// -----------------------------------------------------------------------------
// tb_div_arb
// Self-checking bench for div_arb. A behavioural divider stands in for the
// shared restoring divider: it outputs junk until STEPS steps after a load,
// then the true result. Expected results, ack owner and ack timing come from a
// plain arithmetic / round-robin model kept here.
// -----------------------------------------------------------------------------
module tb_div_arb;

    localparam int W     = 4;
    localparam int STEPS = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_arb_if #(.W(W)) bus ();

    div_arb #(.W(W), .STEPS(STEPS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int last_g   = 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural divider ----------------
    logic [W-1:0]   m_a = '0;
    logic [W-1:0]   m_b = '0;
    int             m_steps = STEPS;
    logic [W-1:0]   ry_m = '0;
    logic [2*W-1:0] ra_m = '0;

    assign bus.div_ry = ry_m;
    assign bus.div_ra = ra_m;

    always @(posedge clk) begin
        if (bus.div_ld) begin
            m_a     <= bus.div_a;
            m_b     <= bus.div_b;
            m_steps <= 0;
            ry_m    <= W'($urandom);
            ra_m    <= (2*W)'($urandom);
        end else if (m_steps < STEPS) begin
            m_steps <= m_steps + 1;
            if (m_steps + 1 == STEPS) begin
                ry_m <= (m_b == '0) ? '1 : m_a / m_b;
                ra_m <= {W'($urandom), ((m_b == '0) ? m_a : m_a % m_b)};
            end else begin
                ry_m <= W'($urandom);
                ra_m <= (2*W)'($urandom);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic dz);
        if (b == '0) begin
            q = '1; r = a; dz = 1'b1;
        end else begin
            q = a / b; r = a % b; dz = 1'b0;
        end
    endfunction

    function automatic int ref_lat(input logic [W-1:0] b);
        return (b == '0) ? 1 : STEPS + 3;
    endfunction

    function automatic int predict(input bit p0, input bit p1);
        if (p0 && p1) return (last_g == 1) ? 0 : 1;
        return p1 ? 1 : 0;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_ack0"},  32'(bus.ack0),   0);
        check({tag, "_ack1"},  32'(bus.ack1),   0);
        check({tag, "_busy"},  32'(bus.busy),   0);
        check({tag, "_ld"},    32'(bus.div_ld), 0);
        check({tag, "_dz"},    32'(bus.dz),     0);
        check({tag, "_q"},     32'(bus.q),      0);
        check({tag, "_r"},     32'(bus.r),      0);
        check({tag, "_div_a"}, 32'(bus.div_a),  0);
        check({tag, "_div_b"}, 32'(bus.div_b),  0);
    endtask

    // One request from a single requester; starts and ends on a negedge.
    task automatic single(input bit who, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eq, er;
        logic         edz;
        int lat = 0, ld_n = 0, ld_at = 0, ack_n = 0, other = 0;
        ref_div(a, b, eq, er, edz);
        if (who == 0) begin bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1; end
        else          begin bus.a1 = a; bus.b1 = b; bus.req1 = 1'b1; end
        for (int k = 1; k <= STEPS + 8; k++) begin
            @(negedge clk);
            if (bus.div_ld) begin ld_n++; ld_at = k; end
            if ((who == 0) ? bus.ack1 : bus.ack0) other++;
            if ((who == 0) ? bus.ack0 : bus.ack1) begin
                ack_n++;
                if (ack_n == 1) begin
                    lat = k;
                    check("s_q",  32'(bus.q),  32'(eq));
                    check("s_r",  32'(bus.r),  32'(er));
                    check("s_dz", 32'(bus.dz), 32'(edz));
                    bus.req0 = 1'b0;
                    bus.req1 = 1'b0;
                end
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        last_g = who;
        check("s_latency",   32'(lat),   32'(ref_lat(b)));
        check("s_ack_count", 32'(ack_n), 1);
        check("s_wrong_ack", 32'(other), 0);
        check("s_ld_count",  32'(ld_n),  (b != '0) ? 1 : 0);
        if (b != '0) check("s_ld_cycle", 32'(ld_at), 1);
        check("s_q_held", 32'(bus.q), 32'(eq));
        check("s_busy_end", 32'(bus.busy), 0);
    endtask

    // Several grants with one or both requesters active. With hold=1 requests
    // stay high through their acks until n acks are seen; otherwise each
    // requester drops at its own ack. Starts and ends on a negedge.
    task automatic multi(input int n, input bit p0, input bit p1, input bit hold,
                         input logic [W-1:0] xa0, input logic [W-1:0] xb0,
                         input logic [W-1:0] xa1, input logic [W-1:0] xb1);
        bit pend0 = p0, pend1 = p1;
        int got = 0, since = 0, g, exp_gap;
        logic [W-1:0] eq, er;
        logic         edz;
        bus.a0 = xa0; bus.b0 = xb0; bus.a1 = xa1; bus.b1 = xb1;
        bus.req0 = p0; bus.req1 = p1;
        g = predict(pend0, pend1);
        exp_gap = ref_lat((g == 1) ? xb1 : xb0);
        for (int k = 0; k < 20 * n + 20 && got < n; k++) begin
            @(negedge clk);
            since++;
            if (bus.ack0 && bus.ack1) check("m_both_ack", 1, 0);
            if (bus.ack0 || bus.ack1) begin
                if (g == 1) ref_div(xa1, xb1, eq, er, edz);
                else        ref_div(xa0, xb0, eq, er, edz);
                check("m_grant_id", 32'(bus.ack1), 32'(g));
                check("m_gap",      32'(since),    32'(exp_gap));
                check("m_q",        32'(bus.q),    32'(eq));
                check("m_r",        32'(bus.r),    32'(er));
                check("m_dz",       32'(bus.dz),   32'(edz));
                last_g = g;
                got++;
                since = 0;
                if (got == n) begin
                    pend0 = 0; pend1 = 0;
                end else if (!hold) begin
                    if (g == 1) pend1 = 0; else pend0 = 0;
                end
                bus.req0 = pend0;
                bus.req1 = pend1;
                if (got < n) begin
                    g = predict(pend0, pend1);
                    exp_gap = 1 + ref_lat((g == 1) ? xb1 : xb0);
                end
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        check("m_done", 32'(got), 32'(n));
        @(negedge clk);
        @(negedge clk);
        check("m_idle_ack", 32'(bus.ack0 | bus.ack1), 0);
        check("m_idle_busy", 32'(bus.busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        last_g = 1;
        @(negedge clk);

        // Basic divide, zero-divisor bypass, tie, alternation under hold.
        single(0, 4'd13, 4'd3);
        single(1, 4'd7, 4'd0);
        multi(2, 1, 1, 0, 4'd15, 4'd1, 4'd9, 4'd2);
        multi(4, 1, 1, 1, 4'd15, 4'd1, 4'd9, 4'd2);

        // Reset in cycle 3 of an operation owned by requester 0.
        bus.a0 = 4'd13; bus.b0 = 4'd3; bus.req0 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus.req0 = 1'b0;
        @(negedge clk);
        check_zero("midrun_reset");
        rst = 1'b1;
        last_g = 1;
        @(negedge clk);
        check("post_reset_idle", 32'(bus.busy | bus.ack0 | bus.ack1), 0);
        multi(2, 1, 1, 0, 4'd11, 4'd4, 4'd6, 4'd5);

        // Exhaustive operand sweep through requester 0.
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                single(0, W'(a), W'(b));
            end
        end

        // Randomised request patterns and operands.
        for (int i = 0; i < 40; i++) begin
            bit rp0, rp1, rh;
            int rn;
            rp0 = 1'($urandom);
            rp1 = 1'($urandom);
            if (!rp0 && !rp1) rp0 = 1'b1;
            rh = 1'($urandom);
            if (rh) rn = $urandom_range(1, 4);
            else    rn = (rp0 && rp1) ? 2 : 1;
            multi(rn, rp0, rp1, rh, W'($urandom), W'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                  W'($urandom), W'($urandom_range(0, 3) == 0 ? 0 : $urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
